platform_refresher: RTL and testbench

Responder side of the game-state controller's refresh handshake. It owns the platform table and builds it while `loadplat` is high. During play it raises `refresh_en` when the doodle climbs above the scroll threshold. It then scrolls every platform down, respawning any that fall off-screen, and pulses `trigger` to return the game-state controller from Refreshing to Game. The renderer reads the table through a combinational port; the doodle module consumes `scroll_amt` on `trigger`.

---
 rtl/platform_refresher.sv | 167 ++++++++++++++++
 tb/tb_platform_refresher.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_refresher.sv
// Platform table owner for the refresh handshake: builds the table on load,
// requests a scroll when the doodle climbs high, then scrolls and respawns slots.
module platform_refresher #(
    parameter int NUM_PLAT   = 8,
    parameter int SCREEN_H   = 480,
    parameter int SCREEN_W   = 640,
    parameter int PLAT_W     = 64,
    parameter int SPACING    = 60,
    parameter int THRESH     = 200,
    parameter int MAX_SCROLL = 120
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [2:0]  outstate,
    input  logic        loadplat,
    input  logic        frame_tick,
    input  logic [9:0]  doodle_y,
    input  logic [3:0]  plat_idx,
    output logic [9:0]  plat_x,
    output logic [9:0]  plat_y,
    output logic        refresh_en,
    output logic        trigger,
    output logic [9:0]  scroll_amt,
    output logic [15:0] score,
    output logic        busy
);

    localparam logic [9:0]  X_SPAN    = 10'(SCREEN_W - PLAT_W);
    localparam logic [10:0] H_ROWS    = 11'(SCREEN_H);
    localparam logic [9:0]  THR       = 10'(THRESH);
    localparam logic [9:0]  MAXS      = 10'(MAX_SCROLL);
    localparam logic [3:0]  LAST      = 4'(NUM_PLAT - 1);
    localparam logic [4:0]  NP        = 5'(NUM_PLAT);
    localparam logic [9:0]  LFSR_SEED = 10'h2A5;

    // Handshake: refresh_en is a one-cycle request; the controller accepts by
    // moving outstate to 100 or cancels with 011. trigger is a one-cycle
    // completion strobe and scroll_amt is valid only while trigger is high.
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ARMED, S_SCROLL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [9:0]  lfsr_q;
    logic        load_q;
    logic [9:0]  amt_q;
    logic [9:0]  tab_x [16];
    logic [9:0]  tab_y [16];

    logic        load_start, tick_req, last_slot, respawn;
    logic [9:0]  spawn_x, req_diff, req_amt, init_y, cur_y, new_y;
    logic [10:0] sum;
    logic [16:0] score_sum;
    logic [15:0] score_sat;

    assign load_start = loadplat && !load_q;
    assign tick_req   = (outstate == 3'b010) && frame_tick && (doodle_y < THR);
    assign last_slot  = (idx_q == LAST);
    assign spawn_x    = (lfsr_q < X_SPAN) ? lfsr_q : lfsr_q - X_SPAN;
    assign req_diff   = THR - doodle_y;
    assign req_amt    = (req_diff > MAXS) ? MAXS : req_diff;
    assign init_y     = 10'(SCREEN_H - 1 - SPACING * int'(idx_q));
    assign cur_y      = tab_y[idx_q];
    assign sum        = {1'b0, cur_y} + {1'b0, amt_q};
    assign respawn    = (sum >= H_ROWS);
    // A slot that scrolls off the bottom wraps to the top with a fresh x.
    assign new_y      = respawn ? 10'(sum - H_ROWS) : sum[9:0];
    assign score_sum  = {1'b0, score} + {7'b0, amt_q};
    assign score_sat  = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    assign plat_x = ({1'b0, plat_idx} < NP) ? tab_x[plat_idx] : '0;
    assign plat_y = ({1'b0, plat_idx} < NP) ? tab_y[plat_idx] : '0;
    assign busy   = (state_q == S_INIT) || (state_q == S_SCROLL);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (load_start) begin
            state_d = S_INIT;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE:   if (tick_req) state_d = S_ARMED;
                S_INIT: begin
                    idx_d = idx_q + 4'd1;
                    if (last_slot) state_d = S_IDLE;
                end
                S_ARMED: begin
                    if (outstate == 3'b100) begin
                        state_d = S_SCROLL;
                        idx_d   = '0;
                    end else if (outstate == 3'b011) begin
                        state_d = S_IDLE;
                    end
                end
                S_SCROLL: begin
                    idx_d = idx_q + 4'd1;
                    if (last_slot) state_d = S_DONE;
                end
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr_q     <= LFSR_SEED;
            load_q     <= 1'b0;
            amt_q      <= '0;
            refresh_en <= 1'b0;
            trigger    <= 1'b0;
            scroll_amt <= '0;
            score      <= '0;
            for (int k = 0; k < 16; k++) begin
                tab_x[k] <= '0;
                tab_y[k] <= '0;
            end
        end else begin
            lfsr_q     <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
            load_q     <= loadplat;
            refresh_en <= 1'b0;
            if (load_start) begin
                score      <= '0;
                trigger    <= 1'b0;
                scroll_amt <= '0;
            end else begin
                case (state_q)
                    S_INIT: begin
                        tab_x[idx_q] <= spawn_x;
                        tab_y[idx_q] <= init_y;
                    end
                    S_IDLE: begin
                        if (tick_req) begin
                            amt_q      <= req_amt;
                            refresh_en <= 1'b1;
                        end
                    end
                    S_SCROLL: begin
                        tab_y[idx_q] <= new_y;
                        if (respawn) tab_x[idx_q] <= spawn_x;
                        if (last_slot) begin
                            trigger    <= 1'b1;
                            scroll_amt <= amt_q;
                            score      <= score_sat;
                        end
                    end
                    S_DONE: begin
                        trigger    <= 1'b0;
                        scroll_amt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_platform_refresher.sv
// Bench for platform_refresher: work-queue reference model compared every
// cycle, a scroll_amt scoreboard, and directed scenarios with literal values.
module tb_platform_refresher;

    logic        Clock;
    logic        Reset_n;
    logic [2:0]  outstate;
    logic        loadplat;
    logic        frame_tick;
    logic [9:0]  doodle_y;
    logic [3:0]  plat_idx;
    logic [9:0]  plat_x;
    logic [9:0]  plat_y;
    logic        refresh_en;
    logic        trigger;
    logic [9:0]  scroll_amt;
    logic [15:0] score;
    logic        busy;

    platform_refresher dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .outstate   (outstate),
        .loadplat   (loadplat),
        .frame_tick (frame_tick),
        .doodle_y   (doodle_y),
        .plat_idx   (plat_idx),
        .plat_x     (plat_x),
        .plat_y     (plat_y),
        .refresh_en (refresh_en),
        .trigger    (trigger),
        .scroll_amt (scroll_amt),
        .score      (score),
        .busy       (busy)
    );

    // clock/reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // reference model: pending work is a queue of per-cycle operations
    typedef enum int {K_INIT, K_SCROLL, K_DONE} kind_t;
    typedef struct {
        kind_t kind;
        int    slot;
    } op_t;

    op_t        m_ops[$];
    int         m_x[16];
    int         m_y[16];
    logic [9:0] m_lfsr;
    int         m_score;
    int         m_amt;
    bit         m_armed;
    bit         m_lp;
    bit         m_req;

    function automatic int spawn_of(input logic [9:0] r);
        if (int'(r) < 576) return int'(r);
        return int'(r) - 576;
    endfunction

    function automatic logic [9:0] lfsr_next(input logic [9:0] r);
        return {r[8:0], r[9] ^ r[6]};
    endfunction

    task automatic push_op(input kind_t k, input int s);
        op_t o;
        o.kind = k;
        o.slot = s;
        m_ops.push_back(o);
    endtask

    task automatic model_reset();
        m_ops.delete();
        for (int i = 0; i < 16; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
        end
        m_lfsr  = 10'h2A5;
        m_score = 0;
        m_amt   = 0;
        m_armed = 0;
        m_lp    = 0;
        m_req   = 0;
    endtask

    task automatic model_step();
        op_t op;
        int  sp;
        int  s;
        int  d;
        sp    = spawn_of(m_lfsr);
        m_req = 0;
        if (loadplat && !m_lp) begin
            m_ops.delete();
            for (int i = 0; i < 8; i++) push_op(K_INIT, i);
            m_armed = 0;
            m_score = 0;
        end else if (m_ops.size() > 0) begin
            op = m_ops.pop_front();
            if (op.kind == K_INIT) begin
                m_x[op.slot] = sp;
                m_y[op.slot] = 479 - 60 * op.slot;
            end else if (op.kind == K_SCROLL) begin
                s = m_y[op.slot] + m_amt;
                if (s >= 480) begin
                    m_y[op.slot] = s - 480;
                    m_x[op.slot] = sp;
                end else begin
                    m_y[op.slot] = s;
                end
            end
            if (m_ops.size() > 0 && m_ops[0].kind == K_DONE)
                m_score = (m_score + m_amt > 65535) ? 65535 : m_score + m_amt;
        end else if (m_armed) begin
            if (outstate == 3'b100) begin
                for (int i = 0; i < 8; i++) push_op(K_SCROLL, i);
                push_op(K_DONE, 0);
                m_armed = 0;
            end else if (outstate == 3'b011) begin
                m_armed = 0;
            end
        end else if (outstate == 3'b010 && frame_tick && int'(doodle_y) < 200) begin
            d       = 200 - int'(doodle_y);
            m_amt   = (d > 120) ? 120 : d;
            m_armed = 1;
            m_req   = 1;
        end
        m_lp   = loadplat;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) model_reset();
        else model_step();
    end

    // scoreboard + per-cycle compare
    logic [9:0] exp_q[$];
    int         trig_seen = 0;

    always @(negedge Clock) begin
        bit e_busy;
        bit e_trig;
        int e_x;
        int e_y;
        e_busy = (m_ops.size() > 0) && (m_ops[0].kind != K_DONE);
        e_trig = (m_ops.size() > 0) && (m_ops[0].kind == K_DONE);
        e_x    = (int'(plat_idx) < 8) ? m_x[plat_idx] : 0;
        e_y    = (int'(plat_idx) < 8) ? m_y[plat_idx] : 0;
        chk("refresh_en", 32'(refresh_en), 32'(m_req));
        chk("trigger", 32'(trigger), 32'(e_trig));
        chk("scroll_amt", 32'(scroll_amt), e_trig ? 32'(m_amt) : 32'd0);
        chk("score", 32'(score), 32'(m_score));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("plat_x", 32'(plat_x), 32'(e_x));
        chk("plat_y", 32'(plat_y), 32'(e_y));
        if (trigger) begin
            trig_seen++;
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("sb_amt", 32'(scroll_amt), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge Clock);
        #1;
        plat_idx = plat_idx + 4'd1;
    endtask

    task automatic read_slot(input int i, output int x, output int y);
        @(posedge Clock);
        #1;
        plat_idx = 4'(i);
        #1;
        x = int'(plat_x);
        y = int'(plat_y);
    endtask

    task automatic do_scroll(input int dy, input int amt, input string tag);
        int n;
        outstate   = 3'b010;
        doodle_y   = 10'(dy);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk({tag, "_refresh_en"}, 32'(refresh_en), 32'd1);
        exp_q.push_back(10'(amt));
        step();
        outstate = 3'b100;
        n = 1;
        while (!trigger && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd10);
        outstate = 3'b010;
        step();
    endtask

    int y_load[8] = '{479, 419, 359, 299, 239, 179, 119, 59};
    int snap_x[8];
    int snap_y[8];

    initial begin
        int busy_n;
        int x;
        int y;
        int t0;

        Reset_n    = 1'b0;
        outstate   = 3'b000;
        loadplat   = 1'b0;
        frame_tick = 1'b0;
        doodle_y   = 10'd300;
        plat_idx   = 4'd0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_refresh_en", 32'(refresh_en), 32'd0);
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_scroll_amt", 32'(scroll_amt), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_plat_x", 32'(plat_x), 32'd0);
        chk("rst_plat_y", 32'(plat_y), 32'd0);
        Reset_n = 1'b1;
        step();
        chk("model_lfsr_1", 32'(m_lfsr), 32'h14B);
        step();
        chk("model_lfsr_2", 32'(m_lfsr), 32'h297);

        // load
        outstate = 3'b001;
        loadplat = 1'b1;
        step();
        loadplat = 1'b0;
        busy_n = 0;
        repeat (12) begin
            @(negedge Clock);
            if (busy) busy_n++;
        end
        chk("load_busy_cycles", 32'(busy_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            read_slot(i, x, y);
            chk("load_y", 32'(y), 32'(y_load[i]));
            chk("load_x_range", 32'(x < 576), 32'd1);
            chk("load_x_model", 32'(x), 32'(m_x[i]));
        end
        read_slot(9, x, y);
        chk("oob_x", 32'(x), 32'd0);
        chk("oob_y", 32'(y), 32'd0);

        // first scroll
        do_scroll(150, 50, "s2");
        chk("s2_score", 32'(score), 32'd50);
        read_slot(1, x, y);
        chk("s2_slot1_y", 32'(y), 32'd469);
        read_slot(7, x, y);
        chk("s2_slot7_y", 32'(y), 32'd109);
        read_slot(0, x, y);
        chk("s2_slot0_y", 32'(y), 32'd49);
        chk("s2_slot0_x", 32'(x), 32'(m_x[0]));

        // clamp, smallest amount, threshold
        do_scroll(20, 120, "s3a");
        chk("s3a_score", 32'(score), 32'd170);
        do_scroll(199, 1, "s3b");
        chk("s3b_score", 32'(score), 32'd171);
        outstate   = 3'b010;
        doodle_y   = 10'd200;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("s3_no_req", 32'(refresh_en), 32'd0);
        repeat (3) step();
        chk("s3_idle", 32'(busy), 32'd0);

        // pause beats the request
        for (int i = 0; i < 8; i++) read_slot(i, snap_x[i], snap_y[i]);
        t0         = trig_seen;
        doodle_y   = 10'd150;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("s4_refresh_en", 32'(refresh_en), 32'd1);
        outstate = 3'b011;
        repeat (15) step();
        chk("s4_no_trigger", 32'(trig_seen - t0), 32'd0);
        chk("s4_score", 32'(score), 32'd171);
        for (int i = 0; i < 8; i++) begin
            read_slot(i, x, y);
            chk("s4_x_kept", 32'(x), 32'(snap_x[i]));
            chk("s4_y_kept", 32'(y), 32'(snap_y[i]));
        end
        do_scroll(150, 50, "s4r");
        chk("s4r_score", 32'(score), 32'd221);

        // abort in the 4th scroll cycle
        t0         = trig_seen;
        outstate   = 3'b010;
        doodle_y   = 10'd150;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("s5_refresh_en", 32'(refresh_en), 32'd1);
        step();
        outstate = 3'b100;
        step();
        repeat (3) step();
        chk("s5_busy_scroll", 32'(busy), 32'd1);
        loadplat = 1'b1;
        step();
        loadplat = 1'b0;
        outstate = 3'b001;
        repeat (20) step();
        chk("s5_no_trigger", 32'(trig_seen - t0), 32'd0);
        chk("s5_score", 32'(score), 32'd0);
        for (int i = 0; i < 8; i++) begin
            read_slot(i, x, y);
            chk("s5_y", 32'(y), 32'(y_load[i]));
            chk("s5_x_model", 32'(x), 32'(m_x[i]));
        end

        // saturation
        for (int k = 0; k < 545; k++) do_scroll(20, 120, "s6_fill");
        do_scroll(100, 100, "s6_top");
        chk("s6_preload", 32'(score), 32'd65500);
        do_scroll(20, 120, "s6_sat");
        chk("s6_saturated", 32'(score), 32'd65535);

        // async reset in the middle of a scroll
        outstate   = 3'b010;
        doodle_y   = 10'd150;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        outstate = 3'b100;
        repeat (3) step();
        chk("s6_busy_before_reset", 32'(busy), 32'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("arst_refresh_en", 32'(refresh_en), 32'd0);
        chk("arst_trigger", 32'(trigger), 32'd0);
        chk("arst_scroll_amt", 32'(scroll_amt), 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_plat_x", 32'(plat_x), 32'd0);
        chk("arst_plat_y", 32'(plat_y), 32'd0);
        plat_idx = 4'd1;
        #1;
        chk("arst_slot1_y", 32'(plat_y), 32'd0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n  = 1'b1;
        outstate = 3'b000;
        repeat (4) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
